// File: rtl/display_mode_ctrl_if.sv
// CPU-side request/status bundle for display_mode_ctrl.
// The register block writes mode requests; status flows back.
interface display_mode_ctrl_if;
  logic mode_req_wr;
  logic mode_req_data;
  logic busy;
  logic switch_done;

  modport master (
    output mode_req_wr,
    output mode_req_data,
    input  busy,
    input  switch_done
  );

  modport slave (
    input  mode_req_wr,
    input  mode_req_data,
    output busy,
    output switch_done
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Frame-aligned text/graphics mux select with forced blanking around each switch.
// Optional stalled-timing watchdog enabled by defining DISPLAY_MODE_CTRL_WDOG_EN.
module display_mode_ctrl #(
  parameter bit RESET_MODE   = 1'b0,
  parameter int BLANK_FRAMES = 2,
  parameter int WDOG_CYCLES  = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  display_mode_ctrl_if.slave   req,
  input  logic                 frame_start,
  output logic                 display_mode,
  output logic                 blank,
  output logic                 wdog_flag
);

  if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15 || WDOG_CYCLES < 1) begin : g_bad_param
    $error("display_mode_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_FS = 2'd1,
    BLANKED = 2'd2,
    UNBLANK = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       mode_q, mode_nxt;
  logic       blank_q, blank_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       target_q, target_nxt;
  logic [3:0] cnt_q, cnt_nxt;
  logic       pend_valid_q, pend_valid_nxt;
  logic       pend_val_q, pend_val_nxt;
  logic       fs_eff;
  logic       tgt_eff;
  logic       pend_any;
  logic       pend_sel;

`ifdef DISPLAY_MODE_CTRL_WDOG_EN
  // A timeout stands in for the missing frame_start so blanking always ends.
  logic [31:0] wdog_cnt;
  logic        wdog_fire;
  logic        wdog_flag_q;

  assign wdog_fire = (state != IDLE) && (wdog_cnt == 32'(WDOG_CYCLES - 1));
  assign fs_eff    = frame_start | wdog_fire;
  assign wdog_flag = wdog_flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt    <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      wdog_flag_q <= wdog_flag_q | wdog_fire;
      if (state == IDLE || fs_eff || state_nxt != state)
        wdog_cnt <= '0;
      else
        wdog_cnt <= wdog_cnt + 32'd1;
    end
  end
`else
  assign fs_eff    = frame_start;
  assign wdog_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= RESET_MODE;
      blank_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      target_q     <= RESET_MODE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      mode_q       <= mode_nxt;
      blank_q      <= blank_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      target_q     <= target_nxt;
      cnt_q        <= cnt_nxt;
      pend_valid_q <= pend_valid_nxt;
      pend_val_q   <= pend_val_nxt;
    end
  end

  // A write in the same cycle as a frame boundary is folded in before the boundary is acted on.
  assign tgt_eff  = req.mode_req_wr ? req.mode_req_data : target_q;
  assign pend_any = pend_valid_q | req.mode_req_wr;
  assign pend_sel = req.mode_req_wr ? req.mode_req_data : pend_val_q;

  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode_q;
    blank_nxt      = blank_q;
    busy_nxt       = busy_q;
    done_nxt       = 1'b0;
    target_nxt     = target_q;
    cnt_nxt        = cnt_q;
    pend_valid_nxt = pend_valid_q;
    pend_val_nxt   = pend_val_q;

    case (state)
      IDLE: begin
        if (req.mode_req_wr && (req.mode_req_data != mode_q)) begin
          target_nxt = req.mode_req_data;
          busy_nxt   = 1'b1;
          state_nxt  = WAIT_FS;
        end
      end

      WAIT_FS: begin
        target_nxt = tgt_eff;
        if (fs_eff) begin
          blank_nxt = 1'b1;
          cnt_nxt   = 4'(BLANK_FRAMES);
          state_nxt = BLANKED;
        end
      end

      BLANKED: begin
        target_nxt = tgt_eff;
        if (fs_eff) begin
          cnt_nxt = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            mode_nxt  = tgt_eff;
            state_nxt = UNBLANK;
          end
        end
      end

      UNBLANK: begin
        if (req.mode_req_wr) begin
          pend_valid_nxt = 1'b1;
          pend_val_nxt   = req.mode_req_data;
        end
        if (fs_eff) begin
          done_nxt       = 1'b1;
          pend_valid_nxt = 1'b0;
          // A pending request for the other source chains straight into another blanked run.
          if (pend_any && (pend_sel != mode_q)) begin
            target_nxt = pend_sel;
            cnt_nxt    = 4'(BLANK_FRAMES);
            state_nxt  = BLANKED;
          end else begin
            blank_nxt = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign display_mode    = mode_q;
  assign blank           = blank_q;
  assign req.busy        = busy_q;
  assign req.switch_done = done_q;

endmodule
